fetch_stage: RTL and testbench

//  Instruction fetch stage plus IF/ID boundary for the 3-stage RISC-V core.
//  - Owns the PC and drives the byte address to the synchronous-read BIOS/IMEM.
//  - Selects the returning word by PC[30] and presents it to decode/imm_gen as (id_pc_o, id_instr_o, id_valid_o).
//  - Handles stall, EX redirect, post-reset empty pipeline and an optional early JAL.

---
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: the stall/redirect controls from the later stages,
// the instruction-memory address and returning data, and the IF/ID outputs
// toward decode/imm_gen.
// The master side is the fetch stage; the slave side is the rest of the core
// (or the testbench), which drives the controls and the memory read data.
interface fetch_if;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] bios_dout_i;
  logic [31:0] imem_dout_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic        id_valid_o;
  logic        id_pred_taken_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, bios_dout_i, imem_dout_i,
    output imem_addr_o, id_pc_o, id_instr_o, id_valid_o, id_pred_taken_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, bios_dout_i, imem_dout_i,
    input  imem_addr_o, id_pc_o, id_instr_o, id_valid_o, id_pred_taken_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage plus the IF/ID boundary of the 3-stage RISC-V core.
// Owns the PC, drives the byte address of the next fetch to the synchronous
// BIOS/IMEM (data returns one cycle later, aligned with pc_q), selects the
// returning word by pc_q[30] and presents it to decode.
// Optional feature macro: FETCH_JAL_EARLY_EN -- when defined, a JAL sitting in
// the ID slot redirects fetch immediately (0-bubble JAL) and is flagged on
// id_pred_taken_o; when undefined, JAL is resolved by the EX redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h4000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master bus
);

  localparam logic [6:0] OPC_JAL = 7'b1101111;

  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] next_pc;
  logic [31:0] id_instr;
  logic        jal_early;
  logic [31:0] jal_target;

  // Word in the ID slot: memory data for pc_q once the slot is live, NOP otherwise
  always_comb begin
    id_instr = NOP_INSTR;
    if (valid_q) begin
      id_instr = pc_q[30] ? bus.bios_dout_i : bus.imem_dout_i;
    end
  end

`ifdef FETCH_JAL_EARLY_EN
  // Spot a live JAL in ID that nothing upstream is overriding; compute its target
  always_comb begin
    jal_early  = valid_q && !bus.stall_i && !bus.redirect_i &&
                 (id_instr[6:0] == OPC_JAL);
    jal_target = pc_q + {{12{id_instr[31]}}, id_instr[19:12], id_instr[20],
                         id_instr[30:21], 1'b0};
  end
`else
  // Without early JAL the fetch stage never redirects itself
  always_comb begin
    jal_early  = 1'b0;
    jal_target = pc_q + 32'd4;
  end
`endif

  // Next-PC selection; reset forces the BIOS base so the address is clean during rst
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (rst) begin
      next_pc = RESET_PC;
    end else if (bus.redirect_i) begin
      next_pc = bus.redirect_pc_i;
    end else if (bus.stall_i) begin
      next_pc = pc_q;
    end else if (!valid_q) begin
      // First fetch after reset: pc_q has not been issued yet
      next_pc = pc_q;
    end else if (jal_early) begin
      next_pc = jal_target;
    end
  end

  // PC and slot-valid registers; a stall holds the slot unless a redirect overrides it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      pc_q <= next_pc;
      if (!(bus.stall_i && !bus.redirect_i)) begin
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.imem_addr_o     = next_pc;
  assign bus.id_pc_o         = pc_q;
  assign bus.id_instr_o      = id_instr;
  // The wrong-path instruction is killed in the cycle EX redirects
  assign bus.id_valid_o      = valid_q && !bus.redirect_i;
  assign bus.id_pred_taken_o = jal_early;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. A table of directed per-cycle vectors
// carries the hand-computed expected outputs; the driver applies one vector per
// cycle and queues it, and a monitor on the falling edge pops and compares.
// BIOS/IMEM are modelled as synchronous-read memories whose contents encode
// the word address, so the selected memory and the fetch latency are visible.
module tb_fetch_stage;

`ifdef FETCH_JAL_EARLY_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] JAL16 = 32'h0100_006F;

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic        jal_mode;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic [31:0] pc;
    logic        valid;
    logic [1:0]  sel;   // 0: NOP, 1: BIOS word of pc, 2: IMEM word of pc
    logic        pred;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic jal_mode = 1'b0;
  logic [31:0] mem_addr_q = 32'h0;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_mon = 0;

  fetch_if bus ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bios_word(input logic [31:0] a, input logic jm);
    if (jm && a[13:2] == 12'd0) return JAL16;
    return {4'hB, 2'b00, a[13:2], 7'h00, 7'h13};
  endfunction

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {4'hA, a[15:2], 7'h00, 7'h13};
  endfunction

  // Synchronous-read memories: data for an address appears one cycle later
  always @(posedge clk) mem_addr_q <= bus.imem_addr_o;
  assign bus.bios_dout_i = bios_word(mem_addr_q, jal_mode);
  assign bus.imem_dout_i = imem_word(mem_addr_q);

  task automatic add(input logic r, input logic s, input logic rd, input logic j,
                     input logic [31:0] rpc, input logic [31:0] addr,
                     input logic [31:0] pc, input logic v, input logic [1:0] sel,
                     input logic pred);
    vec_t t;
    t.rst = r; t.stall = s; t.redirect = rd; t.jal_mode = j; t.rpc = rpc;
    t.addr = addr; t.pc = pc; t.valid = v; t.sel = sel; t.pred = pred;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec %0d %s: got %08h expected %08h", idx, name, act, exp);
    end
  endtask

  // Monitor: compare the DUT outputs of each applied vector mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      logic [31:0] ei;
      e = exp_q.pop_front();
      ei = (e.sel == 2'd1) ? bios_word(e.pc, e.jal_mode) :
           (e.sel == 2'd2) ? imem_word(e.pc) : NOP;
      check("imem_addr", n_mon, bus.imem_addr_o, e.addr);
      check("id_pc", n_mon, bus.id_pc_o, e.pc);
      check("id_valid", n_mon, {31'b0, bus.id_valid_o}, {31'b0, e.valid});
      check("id_instr", n_mon, bus.id_instr_o, ei);
      check("id_pred_taken", n_mon, {31'b0, bus.id_pred_taken_o}, {31'b0, e.pred});
      $display("vec %0d rst=%0b stall=%0b redir=%0b addr=%08h pc=%08h instr=%08h valid=%0b pred=%0b",
               n_mon, e.rst, e.stall, e.redirect, bus.imem_addr_o, bus.id_pc_o,
               bus.id_instr_o, bus.id_valid_o, bus.id_pred_taken_o);
      n_mon++;
    end
  end

  initial begin
    bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 32'h0;

    // T1: reset, then release
    add(1, 0, 0, 0, 32'h0, 32'h4000_0000, 32'h4000_0000, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0, 32'h4000_0000, 32'h4000_0000, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0, 32'h4000_0000, 32'h4000_0000, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0, 32'h4000_0004, 32'h4000_0000, 1, 1, 0);
    add(0, 0, 0, 0, 32'h0, 32'h4000_0008, 32'h4000_0004, 1, 1, 0);
    // T2: three stall cycles at 40000008, then resume
    add(0, 1, 0, 0, 32'h0, 32'h4000_0008, 32'h4000_0008, 1, 1, 0);
    add(0, 1, 0, 0, 32'h0, 32'h4000_0008, 32'h4000_0008, 1, 1, 0);
    add(0, 1, 0, 0, 32'h0, 32'h4000_0008, 32'h4000_0008, 1, 1, 0);
    add(0, 0, 0, 0, 32'h0, 32'h4000_000C, 32'h4000_0008, 1, 1, 0);
    add(0, 0, 0, 0, 32'h0, 32'h4000_0010, 32'h4000_000C, 1, 1, 0);
    // T3: redirect to IMEM 10000010, wrong-path slot killed
    add(0, 0, 1, 0, 32'h1000_0010, 32'h1000_0010, 32'h4000_0010, 0, 1, 0);
    add(0, 0, 0, 0, 32'h0, 32'h1000_0014, 32'h1000_0010, 1, 2, 0);
    add(0, 0, 0, 0, 32'h0, 32'h1000_0018, 32'h1000_0014, 1, 2, 0);
    // T4: stall and redirect together, redirect wins
    add(0, 1, 1, 0, 32'h1000_0020, 32'h1000_0020, 32'h1000_0018, 0, 2, 0);
    add(0, 0, 0, 0, 32'h0, 32'h1000_0024, 32'h1000_0020, 1, 2, 0);
    add(0, 0, 0, 0, 32'h0, 32'h1000_0028, 32'h1000_0024, 1, 2, 0);
    add(0, 0, 0, 0, 32'h0, 32'h1000_002C, 32'h1000_0028, 1, 2, 0);
    // T5: stall at 1000002C, reset arrives mid-stall, T1 repeats
    add(0, 1, 0, 0, 32'h0, 32'h1000_002C, 32'h1000_002C, 1, 2, 0);
    add(1, 1, 0, 0, 32'h0, 32'h4000_0000, 32'h4000_0000, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0, 32'h4000_0000, 32'h4000_0000, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0, 32'h4000_0004, 32'h4000_0000, 1, 1, 0);
    add(0, 0, 0, 0, 32'h0, 32'h4000_0008, 32'h4000_0004, 1, 1, 0);
    // T6: jal x0,16 at the BIOS base
    add(1, 0, 0, 1, 32'h0, 32'h4000_0000, 32'h4000_0000, 0, 0, 0);
    add(0, 0, 0, 1, 32'h0, 32'h4000_0000, 32'h4000_0000, 0, 0, 0);
    add(0, 0, 0, 1, 32'h0, JAL_EN ? 32'h4000_0010 : 32'h4000_0004,
        32'h4000_0000, 1, 1, JAL_EN);
    add(0, 0, 0, 1, 32'h0, JAL_EN ? 32'h4000_0014 : 32'h4000_0008,
        JAL_EN ? 32'h4000_0010 : 32'h4000_0004, 1, 1, 0);
    // Redirect while the pipeline is still empty after reset
    add(1, 0, 0, 0, 32'h0, 32'h4000_0000, 32'h4000_0000, 0, 0, 0);
    add(0, 0, 1, 0, 32'h1000_0040, 32'h1000_0040, 32'h4000_0000, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0, 32'h1000_0044, 32'h1000_0040, 1, 2, 0);
    // Address wrap at 2^32
    add(0, 0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h1000_0044, 0, 2, 0);
    add(0, 0, 0, 0, 32'h0, 32'h0000_0000, 32'hFFFF_FFFC, 1, 1, 0);
    add(0, 0, 0, 0, 32'h0, 32'h0000_0004, 32'h0000_0000, 1, 2, 0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst;
      jal_mode = vecs[i].jal_mode;
      bus.stall_i = vecs[i].stall;
      bus.redirect_i = vecs[i].redirect;
      bus.redirect_pc_i = vecs[i].rpc;
      exp_q.push_back(vecs[i]);
      n_vec++;
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d vectors unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
